// File: rtl/boot_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader sequencer.
// Optional feature macro: BOOT_CSUM_EN adds a payload XOR checksum byte.
package boot_pkg;

  localparam int MEM_SIZE_DEF     = 4 * 2048;
  localparam int TIMEOUT_CYC_DEF  = 1_000_000;
  localparam int LEN_BYTES        = 4;

  localparam logic [7:0] ON_BYTE_DEF  = 8'hAA;
  localparam logic [7:0] STP_BYTE_DEF = 8'h55;
  localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
  localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
`ifdef BOOT_CSUM_EN
    ST_CSUM,
`endif
    ST_STOP,
    ST_RESP,
    ST_RUN
  } boot_state_e;

endpackage

// File: rtl/boot_loader_ctrl_if.sv
// Byte-stream, transmit, RAM-write and core-control signals of the boot loader.
// master = the sequencer, slave = the surrounding system (UART, RAM, core).
interface boot_loader_ctrl_if #(
  parameter int AW = $clog2(boot_pkg::MEM_SIZE_DEF)
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          core_rstn;
  logic          boot_err;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, mem_we, mem_addr, mem_wdata, core_rstn, boot_err
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, mem_we, mem_addr, mem_wdata, core_rstn, boot_err
  );
endinterface

// File: rtl/boot_loader_ctrl_timeout.sv
// Inter-byte gap watchdog: reloads on every received byte, counts down while
// enabled and pulses o_tc once the gap reaches TIMEOUT_CYC cycles.
module boot_timeout_cnt #(
  parameter int TIMEOUT_CYC = boot_pkg::TIMEOUT_CYC_DEF
) (
  input  logic Clk,
  input  logic Rstn,
  input  logic i_load,
  input  logic i_en,
  output logic o_tc
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] RELOAD = CW'(TIMEOUT_CYC - 1);

  logic [CW-1:0] r_cnt;

  // Reload on a byte or when outside a frame, otherwise count down to zero
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      r_cnt <= RELOAD;
    end else if (i_load || !i_en) begin
      r_cnt <= RELOAD;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  // A byte arriving in the terminal cycle wins over the timeout
  assign o_tc = i_en && !i_load && (r_cnt == '0);
endmodule

// File: rtl/boot_loader_ctrl.sv
// UART boot loader sequencer: parses AA / len32 / payload / [csum] / 55 frames,
// writes payload words to RAM, answers ACK/NAK and then releases the core.
// Optional feature macro: BOOT_CSUM_EN (XOR checksum byte after the payload).
module boot_loader_ctrl
  import boot_pkg::*;
#(
  parameter int         MEM_SIZE    = MEM_SIZE_DEF,
  parameter logic [7:0] ON_BYTE     = ON_BYTE_DEF,
  parameter logic [7:0] STP_BYTE    = STP_BYTE_DEF,
  parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
  parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF,
  parameter int         TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input logic                Clk,
  input logic                Rstn,
  boot_loader_ctrl_if.master bus
);
  localparam int AW = $clog2(MEM_SIZE);

`ifdef BOOT_CSUM_EN
  localparam boot_state_e ST_AFTER_DATA = ST_CSUM;
`else
  localparam boot_state_e ST_AFTER_DATA = ST_STOP;
`endif

  boot_state_e   r_state;
  logic [1:0]    r_byteCnt;
  logic [31:0]   r_len;
  logic [31:0]   r_dataCnt;
  logic [31:0]   r_word;
  logic          r_isAck;
  logic [7:0]    r_txData;
  logic          r_txValid;
  logic          r_memWe;
  logic [AW-1:0] r_memAddr;
  logic [31:0]   r_memWdata;
  logic          r_coreRstn;
  logic          r_bootErr;
`ifdef BOOT_CSUM_EN
  logic [7:0]    r_csum;
`endif

  logic [7:0]  w_rxData;
  logic        w_rxValid;
  logic        w_txReady;
  logic [31:0] w_lenNext;
  logic [31:0] w_wordNext;
  logic        w_frameActive;
  logic        w_timeout;

  assign w_rxData   = bus.rx_data;
  assign w_rxValid  = bus.rx_valid;
  assign w_txReady  = bus.tx_ready;
  assign w_lenNext  = {w_rxData, r_len[31:8]};
  assign w_wordNext = {w_rxData, r_word[31:8]};

  assign w_frameActive = (r_state == ST_LEN) || (r_state == ST_DATA) ||
`ifdef BOOT_CSUM_EN
                         (r_state == ST_CSUM) ||
`endif
                         (r_state == ST_STOP);

  boot_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .Clk   (Clk),
    .Rstn  (Rstn),
    .i_load(w_rxValid),
    .i_en  (w_frameActive),
    .o_tc  (w_timeout)
  );

  // Frame sequencer with all outputs registered
  always_ff @(posedge Clk) begin
    if (!Rstn) begin
      r_state    <= ST_IDLE;
      r_byteCnt  <= '0;
      r_len      <= '0;
      r_dataCnt  <= '0;
      r_word     <= '0;
      r_isAck    <= 1'b0;
      r_txData   <= '0;
      r_txValid  <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_coreRstn <= 1'b0;
      r_bootErr  <= 1'b0;
`ifdef BOOT_CSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_memWe <= 1'b0;
      if (r_memWe) begin
        r_memAddr <= r_memAddr + AW'(4);
      end

      if (w_timeout) begin
        r_state   <= ST_RESP;
        r_txValid <= 1'b1;
        r_txData  <= NAK_BYTE;
        r_isAck   <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_rxValid && (w_rxData == ON_BYTE)) begin
              r_state   <= ST_LEN;
              r_byteCnt <= '0;
              r_len     <= '0;
              r_dataCnt <= '0;
              r_memAddr <= '0;
              r_bootErr <= 1'b0;
            end
          end

          ST_LEN: begin
`ifdef BOOT_CSUM_EN
            r_csum <= '0;
`endif
            if (w_rxValid) begin
              r_len     <= w_lenNext;
              r_byteCnt <= r_byteCnt + 1'b1;
              if (r_byteCnt == 2'(LEN_BYTES - 1)) begin
                if ((w_lenNext[1:0] != 2'b00) || (w_lenNext > 32'(MEM_SIZE))) begin
                  r_state   <= ST_RESP;
                  r_txValid <= 1'b1;
                  r_txData  <= NAK_BYTE;
                  r_isAck   <= 1'b0;
                end else if (w_lenNext == '0) begin
                  r_state <= ST_AFTER_DATA;
                end else begin
                  r_state <= ST_DATA;
                end
              end
            end
          end

          ST_DATA: begin
            if (w_rxValid) begin
              r_word    <= w_wordNext;
              r_dataCnt <= r_dataCnt + 32'd1;
`ifdef BOOT_CSUM_EN
              r_csum    <= r_csum ^ w_rxData;
`endif
              if (r_dataCnt[1:0] == 2'd3) begin
                r_memWe    <= 1'b1;
                r_memWdata <= w_wordNext;
              end
              if ((r_dataCnt + 32'd1) == r_len) begin
                r_state <= ST_AFTER_DATA;
              end
            end
          end

`ifdef BOOT_CSUM_EN
          ST_CSUM: begin
            if (w_rxValid) begin
              if (w_rxData == r_csum) begin
                r_state <= ST_STOP;
              end else begin
                r_state   <= ST_RESP;
                r_txValid <= 1'b1;
                r_txData  <= NAK_BYTE;
                r_isAck   <= 1'b0;
              end
            end
          end
`endif

          ST_STOP: begin
            if (w_rxValid) begin
              r_state   <= ST_RESP;
              r_txValid <= 1'b1;
              if (w_rxData == STP_BYTE) begin
                r_txData <= ACK_BYTE;
                r_isAck  <= 1'b1;
              end else begin
                r_txData <= NAK_BYTE;
                r_isAck  <= 1'b0;
              end
            end
          end

          ST_RESP: begin
            if (r_txValid && w_txReady) begin
              r_txValid <= 1'b0;
              if (r_isAck) begin
                r_state    <= ST_RUN;
                r_coreRstn <= 1'b1;
              end else begin
                r_state   <= ST_IDLE;
                r_bootErr <= 1'b1;
              end
            end
          end

          ST_RUN: begin
            r_coreRstn <= 1'b1;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign bus.tx_data   = r_txData;
  assign bus.tx_valid  = r_txValid;
  assign bus.mem_we    = r_memWe;
  assign bus.mem_addr  = r_memAddr;
  assign bus.mem_wdata = r_memWdata;
  assign bus.core_rstn = r_coreRstn;
  assign bus.boot_err  = r_bootErr;
endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Self-checking bench for boot_loader_ctrl: a table of frames plus hand-written
// timeout, back-pressure, mid-load reset and RUN-state sequences.
// Honours BOOT_CSUM_EN when the design is built with it.
module tb_boot_loader_ctrl;
  import boot_pkg::*;

  localparam int MEM = MEM_SIZE_DEF;
  localparam int AW  = $clog2(MEM);
  localparam int TO  = 64;
  localparam logic [7:0] AA  = ON_BYTE_DEF;
  localparam logic [7:0] STP = STP_BYTE_DEF;
  localparam logic [7:0] ACK = ACK_BYTE_DEF;
  localparam logic [7:0] NAK = NAK_BYTE_DEF;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  boot_loader_ctrl_if #(.AW(AW)) bus ();

  boot_loader_ctrl #(
    .MEM_SIZE   (MEM),
    .ON_BYTE    (ON_BYTE_DEF),
    .STP_BYTE   (STP_BYTE_DEF),
    .ACK_BYTE   (ACK_BYTE_DEF),
    .NAK_BYTE   (NAK_BYTE_DEF),
    .TIMEOUT_CYC(TO)
  ) dut (
    .Clk (clk),
    .Rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    string       name;
    logic [31:0] lenField;
    logic [7:0]  stopByte;
    bit          csumBad;
    bit          expAck;
    int          expWrites;
  } vec_t;

  wr_t        expW[$];
  logic [7:0] expTx[$];
  wr_t        mw;
  vec_t       vecs[8];

  int total  = 0;
  int bad    = 0;
  int txSeen = 0;
  int wrSeen = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop the expected RAM write / transmitted byte as the DUT produces it
  always @(negedge clk) begin
    if (rstn && bus.mem_we) begin
      wrSeen++;
      if (expW.size() == 0) begin
        checkOutput("unexpected_write", 32'(bus.mem_addr), 32'hFFFF_FFFF);
      end else begin
        mw = expW.pop_front();
        checkOutput("wr_addr", 32'(bus.mem_addr), 32'(mw.addr));
        checkOutput("wr_data", bus.mem_wdata, mw.data);
      end
    end
    if (rstn && bus.tx_valid && bus.tx_ready) begin
      txSeen++;
      if (expTx.size() == 0) begin
        checkOutput("unexpected_tx", 32'(bus.tx_data), 32'hFFFF_FFFF);
      end else begin
        checkOutput("tx_data", 32'(bus.tx_data), 32'(expTx.pop_front()));
      end
      checkOutput("core_rstn_at_handshake", 32'(bus.core_rstn), 32'd0);
    end
  end

  function automatic logic [7:0] payloadByte(input int idx, input int k);
    return 8'((17 * (k + 1) + 3 * idx) & 255);
  endfunction

  task automatic resetDut();
    rstn = 1'b0;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    @(posedge clk);
    #1;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic waitResp(input string name, input int budget);
    int s = txSeen;
    int c = 0;
    while (txSeen == s && c < budget) begin
      @(negedge clk);
      c++;
    end
    checkOutput({name, "_resp_seen"}, 32'(txSeen - s), 32'd1);
  endtask

  // Sends one frame; the bench model predicts the RAM words as the payload goes out
  task automatic applyStimulus(input vec_t v, input int idx);
    logic [31:0] word = '0;
    bit lenOk;
    int w0 = wrSeen;
`ifdef BOOT_CSUM_EN
    logic [7:0] xsum = '0;
`endif
    lenOk = (v.lenField[1:0] == 2'b00) && (v.lenField <= 32'(MEM));
    expTx.push_back(v.expAck ? ACK : NAK);
    sendByte(AA);
    for (int i = 0; i < LEN_BYTES; i++) sendByte(v.lenField[8*i +: 8]);
    if (lenOk) begin
      for (int k = 0; k < int'(v.lenField); k++) begin
        logic [7:0] b = payloadByte(idx, k);
        word = {b, word[31:8]};
`ifdef BOOT_CSUM_EN
        xsum = xsum ^ b;
`endif
        if ((k % 4) == 3) expW.push_back('{AW'(k - 3), word});
        sendByte(b);
      end
`ifdef BOOT_CSUM_EN
      sendByte(v.csumBad ? (xsum ^ 8'h01) : xsum);
`endif
      sendByte(v.stopByte);
    end
    waitResp(v.name, 100);
    @(posedge clk);
    #1;
    checkOutput({v.name, "_core_rstn"}, 32'(bus.core_rstn), 32'(v.expAck));
    checkOutput({v.name, "_boot_err"},  32'(bus.boot_err),  32'(!v.expAck));
    checkOutput({v.name, "_tx_valid"},  32'(bus.tx_valid),  32'd0);
    checkOutput({v.name, "_writes"},    32'(wrSeen - w0),   32'(v.expWrites));
    checkOutput({v.name, "_wr_pending"}, 32'(expW.size()),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s;
    int w;
    int c;
    int unstable;
    bit prevAck;

    bus.rx_data  = '0;
    bus.rx_valid = 1'b0;
    bus.tx_ready = 1'b1;

    vecs[0] = '{"len8_ack",      32'd8,           STP,   1'b0, 1'b1, 2};
    vecs[1] = '{"len6_nak",      32'd6,           STP,   1'b0, 1'b0, 0};
    vecs[2] = '{"len4_after_nak", 32'd4,          STP,   1'b0, 1'b1, 1};
    vecs[3] = '{"len_too_big",   32'(MEM + 4),    STP,   1'b0, 1'b0, 0};
    vecs[4] = '{"len0_ack",      32'd0,           STP,   1'b0, 1'b1, 0};
    vecs[5] = '{"bad_stop",      32'd12,          8'h5A, 1'b0, 1'b0, 3};
`ifdef BOOT_CSUM_EN
    vecs[6] = '{"bad_csum",      32'd16,          STP,   1'b1, 1'b0, 4};
`else
    vecs[6] = '{"len16_ack",     32'd16,          STP,   1'b1, 1'b1, 4};
`endif
    vecs[7] = '{"len_max_ack",   32'(MEM),        STP,   1'b0, 1'b1, MEM / 4};

    // Reset values
    resetDut();
    checkOutput("rst_tx_valid",  32'(bus.tx_valid),  32'd0);
    checkOutput("rst_tx_data",   32'(bus.tx_data),   32'd0);
    checkOutput("rst_mem_we",    32'(bus.mem_we),    32'd0);
    checkOutput("rst_mem_addr",  32'(bus.mem_addr),  32'd0);
    checkOutput("rst_mem_wdata", bus.mem_wdata,      32'd0);
    checkOutput("rst_core_rstn", 32'(bus.core_rstn), 32'd0);
    checkOutput("rst_boot_err",  32'(bus.boot_err),  32'd0);

    // Table of frames; a reset is needed to leave RUN after every ACK
    prevAck = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (prevAck) resetDut();
      applyStimulus(vecs[i], i);
      prevAck = vecs[i].expAck;
    end

    // Byte gap after the 2nd payload byte, with the NAK back-pressured for 50 cycles
    resetDut();
    bus.tx_ready = 1'b0;
    expTx.push_back(NAK);
    sendByte(AA);
    sendByte(8'h08); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22);
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!bus.tx_valid && c < TO + 20);
    checkOutput("timeout_gap_cycles", 32'(c), 32'(TO));
    unstable = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== NAK) unstable++;
    end
    checkOutput("tx_hold_stable", 32'(unstable), 32'd0);
    bus.tx_ready = 1'b1;
    waitResp("timeout", 10);
    @(posedge clk);
    #1;
    checkOutput("timeout_boot_err",  32'(bus.boot_err),  32'd1);
    checkOutput("timeout_core_rstn", 32'(bus.core_rstn), 32'd0);

    // Reset pulse in the middle of DATA, after one word has been written
    resetDut();
    expW.push_back('{AW'(0), 32'h4433_2211});
    sendByte(AA);
    sendByte(8'h08); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h11); sendByte(8'h22); sendByte(8'h33); sendByte(8'h44); sendByte(8'h55);
    @(negedge clk);
    rstn = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("abort_tx_valid",  32'(bus.tx_valid),  32'd0);
    checkOutput("abort_tx_data",   32'(bus.tx_data),   32'd0);
    checkOutput("abort_mem_we",    32'(bus.mem_we),    32'd0);
    checkOutput("abort_mem_addr",  32'(bus.mem_addr),  32'd0);
    checkOutput("abort_mem_wdata", bus.mem_wdata,      32'd0);
    checkOutput("abort_core_rstn", 32'(bus.core_rstn), 32'd0);
    checkOutput("abort_boot_err",  32'(bus.boot_err),  32'd0);
    rstn = 1'b1;
    s = txSeen;
    w = wrSeen;
    sendByte(8'h66); sendByte(8'h77); sendByte(8'h88); sendByte(STP);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_idle_no_tx",    32'(txSeen - s), 32'd0);
    checkOutput("abort_idle_no_write", 32'(wrSeen - w), 32'd0);
    applyStimulus('{"after_abort", 32'd4, STP, 1'b0, 1'b1, 1}, 9);

    // Bytes in RUN, including a start byte, are ignored
    s = txSeen;
    w = wrSeen;
    sendByte(AA);
    sendByte(8'h04); sendByte(8'h00); sendByte(8'h00); sendByte(8'h00);
    sendByte(8'h01); sendByte(8'h02); sendByte(8'h03); sendByte(8'h04); sendByte(STP);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("run_no_tx",     32'(txSeen - s),    32'd0);
    checkOutput("run_no_write",  32'(wrSeen - w),    32'd0);
    checkOutput("run_tx_valid",  32'(bus.tx_valid),  32'd0);
    checkOutput("run_core_rstn", 32'(bus.core_rstn), 32'd1);
    checkOutput("tx_queue_empty", 32'(expTx.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
